// File: rtl/bf128_key_loader.sv
// bf128_key_loader: front-end of the Blowfish-128 subkey generator.
// Collects a user key as 32-bit words, packs it onto skeygen's 448-bit key bus,
// sequences skeygen's rst/enable, then waits for skey_ready and flags the P-array valid.
//
// Handshake: a key word transfers on a rising edge where word_valid && word_ready.
// word_ready depends only on the FSM state (high in LOAD only), never on word_valid.
// word_data must be stable while word_valid is high.
module bf128_key_loader #(
  parameter int MAX_WORDS = 14,  // longest key in 32-bit words (key bus holds at most 14)
  parameter int TIMEOUT   = 15   // cycles allowed in WAIT_LO+WAIT_HI
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic [3:0]  len_in,
  input  logic        encrypt_in,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  output logic        word_ready,
  output logic [63:0] key0,
  output logic [63:0] key1,
  output logic [63:0] key2,
  output logic [63:0] key3,
  output logic [63:0] key4,
  output logic [63:0] key5,
  output logic [63:0] key6,
  output logic [63:0] key7,
  output logic [3:0]  key_length,
  output logic        kg_rst,
  output logic        kg_enable,
  output logic        kg_encrypt,
  input  logic        skey_ready,
  output logic        busy,
  output logic        key_valid,
  output logic        key_done,
  output logic        err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CLEAR   = 3'd2,
    S_START   = 3'd3,
    S_WAIT_LO = 3'd4,
    S_WAIT_HI = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam int          TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [3:0]  MAX_LEN  = 4'(MAX_WORDS);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [447:0]       key_q, key_d;
  logic [3:0]         len_q, len_d;
  logic               enc_q, enc_d;
  logic               key_valid_q, key_valid_d;
  logic               key_done_q, key_done_d;
  logic               err_q, err_d;
  logic               kg_rst_q, kg_rst_d;
  logic               kg_en_q, kg_en_d;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath and pulse registers; pulses are registered so skeygen sees glitch-free strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      tmo_q       <= '0;
      key_q       <= '0;
      len_q       <= '0;
      enc_q       <= 1'b0;
      key_valid_q <= 1'b0;
      key_done_q  <= 1'b0;
      err_q       <= 1'b0;
      kg_rst_q    <= 1'b0;
      kg_en_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      key_q       <= key_d;
      len_q       <= len_d;
      enc_q       <= enc_d;
      key_valid_q <= key_valid_d;
      key_done_q  <= key_done_d;
      err_q       <= err_d;
      kg_rst_q    <= kg_rst_d;
      kg_en_q     <= kg_en_d;
    end
  end

  // Next-state and next-register logic; pulses default low and are raised on entry to
  // the state during which they must be visible.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    key_d       = key_q;
    len_d       = len_q;
    enc_d       = enc_q;
    key_valid_d = key_valid_q;
    key_done_d  = 1'b0;
    err_d       = 1'b0;
    kg_rst_d    = 1'b0;
    kg_en_d     = 1'b0;
    word_ready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          if (len_in == 4'd0 || len_in > MAX_LEN) begin
            // Bad length: report it but leave the current key untouched.
            err_d = 1'b1;
          end else begin
            len_d       = len_in;
            enc_d       = encrypt_in;
            key_d       = '0;
            key_valid_d = 1'b0;
            cnt_d       = '0;
            state_d     = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        word_ready = 1'b1;
        if (word_valid) begin
          key_d[cnt_q*32 +: 32] = word_data;
          cnt_d                 = cnt_q + 4'd1;
          if (cnt_q == len_q - 4'd1) begin
            state_d  = S_CLEAR;
            kg_rst_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        // skeygen XORs into its P-array cumulatively, so it was just reset; now start it.
        kg_en_d = 1'b1;
        state_d = S_START;
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        // skey_ready may still be high from the previous key; wait for it to drop.
        tmo_d = tmo_q + 1'b1;
        if (!skey_ready) begin
          state_d = S_WAIT_HI;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_HI: begin
        tmo_d = tmo_q + 1'b1;
        if (skey_ready) begin
          state_d = S_DONE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        key_valid_d = 1'b1;
        key_done_d  = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign key0       = key_q[63:0];
  assign key1       = key_q[127:64];
  assign key2       = key_q[191:128];
  assign key3       = key_q[255:192];
  assign key4       = key_q[319:256];
  assign key5       = key_q[383:320];
  assign key6       = key_q[447:384];
  assign key7       = 64'd0;
  assign key_length = len_q;
  assign kg_rst     = kg_rst_q;
  assign kg_enable  = kg_en_q;
  assign kg_encrypt = enc_q;
  assign busy       = (state_q != S_IDLE);
  assign key_valid  = key_valid_q;
  assign key_done   = key_done_q;
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bf128_key_loader.sv
// Directed bench for bf128_key_loader. Inputs change on the falling edge, outputs are
// sampled on the falling edge (or just after an asynchronous reset).
module tb_bf128_key_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic [3:0]  len_in = 4'd0;
  logic        encrypt_in = 1'b0;
  logic        word_valid = 1'b0;
  logic [31:0] word_data = 32'd0;
  logic        word_ready;
  logic [63:0] key0, key1, key2, key3, key4, key5, key6, key7;
  logic [3:0]  key_length;
  logic        kg_rst, kg_enable, kg_encrypt;
  logic        skey_ready = 1'b0;
  logic        busy, key_valid, key_done, err;
  logic [2:0]  dbg_state;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT_LO = 3'd4;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] words [14];
  logic [63:0] kv [8];
  int cyc;
  int dn;

  bf128_key_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .len_in(len_in),
    .encrypt_in(encrypt_in), .word_valid(word_valid), .word_data(word_data),
    .word_ready(word_ready), .key0(key0), .key1(key1), .key2(key2), .key3(key3),
    .key4(key4), .key5(key5), .key6(key6), .key7(key7), .key_length(key_length),
    .kg_rst(kg_rst), .kg_enable(kg_enable), .kg_encrypt(kg_encrypt),
    .skey_ready(skey_ready), .busy(busy), .key_valid(key_valid), .key_done(key_done),
    .err(err), .dbg_state(dbg_state)
  );

  assign kv[0] = key0; assign kv[1] = key1; assign kv[2] = key2; assign kv[3] = key3;
  assign kv[4] = key4; assign kv[5] = key5; assign kv[6] = key6; assign kv[7] = key7;

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One-cycle load request; returns at the falling edge after it was sampled.
  task automatic start_load(input logic [3:0] len, input logic enc);
    @(negedge clk);
    load_start = 1'b1; len_in = len; encrypt_in = enc;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Pushes words[0..n-1]; returns at the falling edge after the last accepted word.
  task automatic push_words(input int n, input bit gap, input string tag);
    int i; int guard; bit tog; logic acc;
    i = 0; guard = 0; tog = 1'b1;
    while (i < n && guard < 100) begin
      word_valid = gap ? tog : 1'b1;
      tog = ~tog;
      word_data = words[i];
      acc = word_valid & word_ready;
      @(negedge clk);
      if (acc) i++;
      guard++;
    end
    word_valid = 1'b0;
    check(tag, 64'(i), 64'(n));
  endtask

  // Watches a bounded window and counts key_done pulses.
  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      if (key_done) cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset state.
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_word_ready", word_ready, 0);
    check("rst_key0", key0, 0);
    check("rst_key_length", key_length, 0);
    check("rst_kg_pulses", {kg_rst, kg_enable, kg_encrypt}, 0);
    check("rst_flags", {key_valid, key_done, err}, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // Test 1: basic 4-word load.
    words[0] = 32'h00112233; words[1] = 32'h44556677;
    words[2] = 32'h8899AABB; words[3] = 32'hCCDDEEFF;
    start_load(4'd4, 1'b1);
    check("t1_busy", busy, 1);
    check("t1_word_ready", word_ready, 1);
    check("t1_len_enc", {key_length, kg_encrypt}, {4'd4, 1'b1});
    push_words(4, 1'b0, "t1_words");
    check("t1_clear_pulses", {kg_rst, kg_enable}, 2'b10);
    check("t1_clear_ready", word_ready, 0);
    @(negedge clk);
    check("t1_start_pulses", {kg_rst, kg_enable}, 2'b01);
    repeat (2) @(negedge clk);
    check("t1_pulses_gone", {kg_rst, kg_enable}, 2'b00);
    skey_ready = 1'b1;
    count_done(10, dn);
    check("t1_done_count", dn, 1);
    check("t1_key0", key0, 64'h4455667700112233);
    check("t1_key1", key1, 64'hCCDDEEFF8899AABB);
    check("t1_key2", key2, 0);
    check("t1_key7", key7, 0);
    check("t1_valid_busy", {key_valid, busy}, 2'b10);

    // Test 2: illegal lengths 0 and 15.
    start_load(4'd0, 1'b0);
    check("t2_len0_err", {err, busy}, 2'b10);
    @(negedge clk);
    check("t2_len0_err_pulse", err, 0);
    start_load(4'd15, 1'b0);
    check("t2_len15_err", {err, busy}, 2'b10);
    @(negedge clk);
    check("t2_len15_err_pulse", err, 0);
    check("t2_key_kept", {key1, key0}, {64'hCCDDEEFF8899AABB, 64'h4455667700112233});
    check("t2_meta_kept", {key_valid, key_length, kg_encrypt}, {1'b1, 4'd4, 1'b1});

    // Test 3: back-to-back load with skey_ready still high from the last run.
    words[0] = 32'hDEADBEEF; words[1] = 32'h01234567;
    start_load(4'd2, 1'b0);
    check("t3_valid_cleared", key_valid, 0);
    check("t3_keys_zeroed", key1, 0);
    push_words(2, 1'b0, "t3_words");
    check("t3_clear", {kg_rst, kg_enable}, 2'b10);
    @(negedge clk);
    check("t3_start", {kg_rst, kg_enable}, 2'b01);
    count_done(5, dn);
    check("t3_stuck_wait_lo", dbg_state, ST_WAIT_LO);
    check("t3_no_early_done", dn, 0);
    skey_ready = 1'b0;
    count_done(2, dn);
    check("t3_no_done_low", dn, 0);
    skey_ready = 1'b1;
    count_done(10, dn);
    check("t3_done_count", dn, 1);
    check("t3_key0", key0, 64'h01234567DEADBEEF);
    check("t3_enc", {kg_encrypt, key_valid}, 2'b01);

    // Test 4: 14-word load with word_valid toggling every cycle.
    for (int i = 0; i < 14; i++) words[i] = 32'h01010101 * (i + 1);
    start_load(4'd14, 1'b1);
    push_words(14, 1'b1, "t4_words");
    word_valid = 1'b1; word_data = 32'hFFFFFFFF;
    check("t4_clear_ready", word_ready, 0);
    @(negedge clk);
    word_valid = 1'b0;
    skey_ready = 1'b0;
    repeat (2) @(negedge clk);
    skey_ready = 1'b1;
    count_done(10, dn);
    check("t4_done_count", dn, 1);
    for (int i = 0; i < 7; i++)
      check($sformatf("t4_key%0d", i), kv[i], {words[2*i+1], words[2*i]});
    check("t4_key6_hand", key6, 64'h0E0E0E0E0D0D0D0D);
    check("t4_key7", key7, 0);

    // Test 5: skey_ready never rises -> timeout error.
    skey_ready = 1'b0;
    words[0] = 32'hCAFEF00D;
    start_load(4'd1, 1'b0);
    push_words(1, 1'b0, "t5_words");
    @(negedge clk);
    check("t5_start", kg_enable, 1);
    cyc = 0;
    while (!err && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("t5_tmo_cycles", cyc, 16);
    check("t5_idle", {dbg_state, busy, key_valid}, {ST_IDLE, 1'b0, 1'b0});
    @(negedge clk);
    check("t5_err_pulse", err, 0);

    // Test 6: asynchronous reset in the middle of a load.
    words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h33333333;
    start_load(4'd4, 1'b1);
    push_words(2, 1'b0, "t6_partial");
    #2 rst = 1'b1;
    #1;
    check("t6_async_busy", {busy, word_ready}, 2'b00);
    check("t6_async_key0", key0, 0);
    check("t6_async_meta", {key_length, kg_encrypt}, 0);
    @(negedge clk);
    rst = 1'b0;
    start_load(4'd3, 1'b0);
    push_words(3, 1'b0, "t6_words");
    repeat (3) @(negedge clk);
    skey_ready = 1'b1;
    count_done(10, dn);
    check("t6_done_count", dn, 1);
    check("t6_key0", key0, 64'h2222222211111111);
    check("t6_key1", key1, 64'h0000000033333333);
    check("t6_len", key_length, 4'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
